// File: rtl/systolic_mm4x4_pkg.sv
// Shared definitions for the 4x4 INT8 output-stationary systolic multiplier:
// array geometry, operand/accumulator/result widths, FSM state encoding and
// the saturation bounds applied when results leave the array.
package systolic_mm4x4_pkg;

  localparam int N          = 4;            // array dimension (rows = cols = K)
  localparam int W          = 8;            // signed operand width
  localparam int ACC_W      = 2*W + 2;      // accumulator with guard bits
  localparam int OUT_W      = 2*W;          // delivered result width
  localparam int BEAT_W     = $clog2(N);
  localparam int DRAIN_W    = $clog2(2*N - 1);
  localparam int DRAIN_LAST = 2*(N - 1);    // drain steps before results are final

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);
  localparam logic [OUT_W-1:0]        OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]        OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

endpackage

// File: rtl/systolic_mm4x4_if.sv
// Operand/result bus of systolic_mm4x4.
//   start     : begin a multiply (honoured in IDLE only)
//   in_valid  : a_col/b_row beat valid;  in_ready : block accepts beats
//   a_col     : A[i][k] at [i*W +: W];   b_row : B[k][j] at [j*W +: W]
//   res_flat  : C[r][c] at [(r*N+c)*OUT_W +: OUT_W], held until next done
//   done      : one-cycle result strobe; busy : operation in progress
//   sat_flag  : some element of the last result was clamped
interface systolic_mm4x4_if;
  import systolic_mm4x4_pkg::*;

  logic                   start;
  logic                   in_valid;
  logic                   in_ready;
  logic [N*W-1:0]         a_col;
  logic [N*W-1:0]         b_row;
  logic [N*N*OUT_W-1:0]   res_flat;
  logic                   done;
  logic                   busy;
  logic                   sat_flag;

  modport master (
    output start, in_valid, a_col, b_row,
    input  in_ready, res_flat, done, busy, sat_flag
  );

  modport slave (
    input  start, in_valid, a_col, b_row,
    output in_ready, res_flat, done, busy, sat_flag
  );
endinterface

// File: rtl/systolic_mm4x4_pe.sv
// Processing element of the systolic array.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous accumulator clear
//   adv        : latch operands for the neighbours and accumulate a_in*b_in
//   a_in/b_in  : operands from the left / from above
//   a_out/b_out: registered operands to the right / below
//   acc        : signed running sum
module systolic_pe
  import systolic_mm4x4_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    adv,
  input  logic signed [W-1:0]     a_in,
  input  logic signed [W-1:0]     b_in,
  output logic signed [W-1:0]     a_out,
  output logic signed [W-1:0]     b_out,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [W-1:0]     a_q, a_d, b_q, b_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [2*W-1:0]   prod;

  always_comb begin
    prod  = (2*W)'(a_in) * (2*W)'(b_in);
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (adv) begin
      a_d   = a_in;
      b_d   = b_in;
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_mm4x4.sv
// Output-stationary 4x4 INT8 systolic matrix multiplier, C = A x B.
//   clk    : rising-edge clock
//   _reset : asynchronous active-low reset
//   bus    : operand beats in, saturated 16-bit result matrix out
// Beat k carries column k of A and row k of B; after the last beat the array
// drains for 2*(N-1) steps, then the clamped results are registered with done.
module systolic_mm4x4
  import systolic_mm4x4_pkg::*;
(
  input  logic              clk,
  input  logic              _reset,
  systolic_mm4x4_if.slave   bus
);

  state_e                 state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [DRAIN_W-1:0]     drain_q, drain_d;
  logic [N*N*OUT_W-1:0]   res_q, res_d, res_sat;
  logic                   sat_q, sat_d, sat_any;
  logic                   done_q, done_d;
  logic                   clr, adv;

  logic signed [W-1:0]     a_edge [N];
  logic signed [W-1:0]     b_edge [N];
  logic signed [W-1:0]     a_h    [N][N-1];
  logic signed [W-1:0]     b_v    [N-1][N];
  logic signed [ACC_W-1:0] acc_all [N][N];
  // Operands leaving the east/south edges have no consumer.
  logic signed [W-1:0]     unused_a_east  [N];
  logic signed [W-1:0]     unused_b_south [N];

  // Input skew: row i of A and column i of B are delayed i steps.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic signed [W-1:0] a_in, b_in;
    // Zeros are injected while draining so the tail of the array sees no stale data.
    assign a_in = (state_q == FEED) ? bus.a_col[i*W +: W] : '0;
    assign b_in = (state_q == FEED) ? bus.b_row[i*W +: W] : '0;
    if (i == 0) begin : g_direct
      assign a_edge[i] = a_in;
      assign b_edge[i] = b_in;
    end else begin : g_delay
      logic [i*W-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d;
      always_comb begin
        a_sr_d = a_sr_q;
        b_sr_d = b_sr_q;
        if (adv) begin
          a_sr_d = (i*W)'({a_sr_q, a_in});
          b_sr_d = (i*W)'({b_sr_q, b_in});
        end
      end
      always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
          a_sr_q <= '0;
          b_sr_q <= '0;
        end else begin
          a_sr_q <= a_sr_d;
          b_sr_q <= b_sr_d;
        end
      end
      assign a_edge[i] = a_sr_q[(i-1)*W +: W];
      assign b_edge[i] = b_sr_q[(i-1)*W +: W];
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      logic signed [W-1:0] a_i, b_i, a_o, b_o;
      if (c == 0) begin : g_a_src
        assign a_i = a_edge[r];
      end else begin : g_a_link
        assign a_i = a_h[r][c-1];
      end
      if (r == 0) begin : g_b_src
        assign b_i = b_edge[c];
      end else begin : g_b_link
        assign b_i = b_v[r-1][c];
      end
      if (c == N-1) begin : g_a_east
        assign unused_a_east[r] = a_o;
      end else begin : g_a_pass
        assign a_h[r][c] = a_o;
      end
      if (r == N-1) begin : g_b_south
        assign unused_b_south[c] = b_o;
      end else begin : g_b_pass
        assign b_v[r][c] = b_o;
      end
      systolic_pe u_pe (
        .clk   (clk),
        .rst_n (_reset),
        .clr   (clr),
        .adv   (adv),
        .a_in  (a_i),
        .b_in  (b_i),
        .a_out (a_o),
        .b_out (b_o),
        .acc   (acc_all[r][c])
      );
    end
  end

  always_comb begin
    res_sat = '0;
    sat_any = 1'b0;
    for (int unsigned r = 0; r < N; r++) begin
      for (int unsigned c = 0; c < N; c++) begin
        if (acc_all[r][c] > SAT_MAX) begin
          res_sat[(r*N+c)*OUT_W +: OUT_W] = OUT_MAX;
          sat_any = 1'b1;
        end else if (acc_all[r][c] < SAT_MIN) begin
          res_sat[(r*N+c)*OUT_W +: OUT_W] = OUT_MIN;
          sat_any = 1'b1;
        end else begin
          res_sat[(r*N+c)*OUT_W +: OUT_W] = acc_all[r][c][OUT_W-1:0];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    res_d   = res_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    adv     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          clr     = 1'b1;
          beat_d  = '0;
          state_d = FEED;
        end
      end
      FEED: begin
        if (bus.in_valid) begin
          adv    = 1'b1;
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(N-1)) begin
            drain_d = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_W'(DRAIN_LAST)) begin
          res_d   = res_sat;
          sat_d   = sat_any;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          adv     = 1'b1;
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      drain_q <= '0;
      res_q   <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
      res_q   <= res_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
    end
  end

  assign bus.in_ready = (state_q == FEED);
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.res_flat = res_q;
  assign bus.sat_flag = sat_q;

endmodule

// File: tb/tb_systolic_mm4x4.sv
// Self-checking bench for systolic_mm4x4: directed and randomized multiplies
// compared every cycle against a plain integer matrix-product model.
module tb_systolic_mm4x4;

  logic clk = 1'b0;
  logic _reset;
  systolic_mm4x4_if bus ();

  systolic_mm4x4 dut (
    .clk    (clk),
    ._reset (_reset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           due;
    logic [255:0] res;
    logic         sat;
  } exp_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           mA [4][4];
  int           mB [4][4];
  int           gap_pat [7] = '{1, 0, 0, 1, 0, 1, 1};
  exp_t         q [$];
  logic [255:0] exp_res    = '0;
  logic         exp_sat    = 1'b0;
  logic         exp_done   = 1'b0;
  logic         model_busy = 1'b0;
  logic         model_feed = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Result model: integer product, then clamp to the signed 16-bit range.
  function automatic void model_compute(output logic [255:0] r, output logic s);
    int acc, v;
    r = '0;
    s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int k = 0; k < 4; k++) acc += mA[i][k] * mB[k][j];
        if (acc > 32767) begin
          v = 32767; s = 1'b1;
        end else if (acc < -32768) begin
          v = -32768; s = 1'b1;
        end else begin
          v = acc;
        end
        r[(i*4+j)*16 +: 16] = 16'(v);
      end
    end
  endfunction

  always @(negedge clk) begin
    exp_done = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_done   = 1'b1;
      exp_res    = q[0].res;
      exp_sat    = q[0].sat;
      model_busy = 1'b0;
      void'(q.pop_front());
    end
    chk("done",     256'(bus.done),     256'(exp_done));
    chk("res_flat", bus.res_flat,       exp_res);
    chk("sat_flag", 256'(bus.sat_flag), 256'(exp_sat));
    chk("busy",     256'(bus.busy),     256'(model_busy));
    chk("in_ready", 256'(bus.in_ready), 256'(model_feed));
  end

  function automatic int rnd8();
    logic [7:0] t;
    if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) == 1) ? 127 : -128;
    t = 8'($urandom);
    return int'($signed(t));
  endfunction

  task automatic set_random();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mA[i][j] = rnd8();
        mB[i][j] = rnd8();
      end
  endtask

  task automatic set_identity();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mA[i][j] = (i == j) ? 1 : 0;
        mB[i][j] = 10*i + j;
      end
  endtask

  task automatic set_const(input int a, input int b);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mA[i][j] = a;
        mB[i][j] = b;
      end
  endtask

  task automatic drive_beat(input int k);
    for (int i = 0; i < 4; i++) begin
      bus.a_col[i*8 +: 8] = 8'(mA[i][k]);
      bus.b_row[i*8 +: 8] = 8'(mB[k][i]);
    end
  endtask

  // mode: 0 contiguous beats, 1 fixed gap pattern, 2 random gaps + stray starts.
  // post: 0 wait until idle, 1 hold start/in_valid through DRAIN, 2 return on done edge.
  task automatic do_run(input int mode, input int post);
    int k, step;
    logic v;
    logic [255:0] r;
    logic s;
    model_compute(r, s);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    model_busy = 1'b1;
    model_feed = 1'b1;
    k = 0;
    step = 0;
    while (k < 4) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (step < 7) ? gap_pat[step] != 0 : 1'b1;
        default: v = (step > 20) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      bus.in_valid = v;
      if (v) drive_beat(k);
      else begin
        bus.a_col = 32'($urandom);
        bus.b_row = 32'($urandom);
      end
      bus.start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      if (v) k++;
      step++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    model_feed   = 1'b0;
    q.push_back('{due: cyc + 7, res: r, sat: s});
    if (post == 1) begin
      bus.in_valid = 1'b1;
      bus.start    = 1'b1;
      repeat (7) begin
        bus.a_col = 32'($urandom);
        bus.b_row = 32'($urandom);
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
      @(posedge clk); #1;
    end else if (post == 2) begin
      repeat (7) @(posedge clk);
      #1;
    end else begin
      repeat (8) @(posedge clk);
      #1;
    end
  endtask

  task automatic abort_run();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    model_busy = 1'b1;
    model_feed = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1;
      drive_beat(k);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    _reset     = 1'b0;
    q.delete();
    exp_res    = '0;
    exp_sat    = 1'b0;
    model_busy = 1'b0;
    model_feed = 1'b0;
    #1;
    chk("abort_res_zero", bus.res_flat, '0);
    repeat (2) @(posedge clk);
    #1;
    _reset = 1'b1;
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.a_col    = '0;
    bus.b_row    = '0;
    _reset       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_res",  bus.res_flat, '0);
    chk("reset_done", 256'(bus.done), 256'(0));
    chk("reset_busy", 256'(bus.busy), 256'(0));
    _reset = 1'b1;
    // Beats offered while idle must be ignored.
    bus.in_valid = 1'b1;
    bus.a_col    = 32'h7f7f7f7f;
    bus.b_row    = 32'h7f7f7f7f;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;

    set_identity();
    do_run(0, 0);
    chk("ident_c23", 256'(bus.res_flat[(2*4+3)*16 +: 16]), 256'(16'd23));
    chk("ident_c31", 256'(bus.res_flat[(3*4+1)*16 +: 16]), 256'(16'd31));
    chk("ident_sat", 256'(bus.sat_flag), 256'(0));

    set_const(127, 127);
    do_run(0, 0);
    chk("pos_clamp", 256'(bus.res_flat[(1*4+2)*16 +: 16]), 256'(16'h7fff));
    chk("pos_sat",   256'(bus.sat_flag), 256'(1));

    set_const(-128, 127);
    do_run(0, 0);
    chk("neg_clamp", 256'(bus.res_flat[(3*4+0)*16 +: 16]), 256'(16'h8000));
    chk("neg_sat",   256'(bus.sat_flag), 256'(1));

    set_identity();
    do_run(1, 0);
    chk("gap_c12", 256'(bus.res_flat[(1*4+2)*16 +: 16]), 256'(16'd12));

    set_random();
    do_run(0, 0);
    set_random();
    abort_run();
    repeat (10) @(posedge clk);
    #1;
    set_random();
    do_run(2, 1);

    set_random();
    do_run(0, 2);
    set_random();
    do_run(0, 0);

    for (int n = 0; n < 24; n++) begin
      set_random();
      do_run(2, (n == 23) ? 0 : 2 * int'($urandom_range(0, 1)));
    end
    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 256'(q.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end

endmodule
